coder_stream_serializer: RTL

Parametrised output stage for the turbo-coder stack. It accepts the encoder's three parallel streams (systematic xk, parity zk, interleaved parity zk_prime) and buffers them as triplets in a register FIFO. It then serialises them lane by lane onto a single ready/valid output bus for the downstream rate-matching / framing logic. Unlike the fixed 3×8-bit encoder outputs with a bare `out_valid`, it adds configurable width and depth, backpressure, block delimiting, an error flag and an optional rate-1/2 puncturing mode.

---
 rtl/coder_stream_serializer_if.sv | 28 ++
 rtl/coder_stream_serializer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/coder_stream_serializer_if.sv
// Triplet-in / lane-out handshake bundle for coder_stream_serializer.
// The producer/sink side uses master; the serializer itself uses slave.
interface coder_stream_serializer_if #(
  parameter int W = 8
);
  logic [W-1:0] xk_in;
  logic [W-1:0] zk_in;
  logic [W-1:0] zk_prime_in;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         rate_half;
  logic [W-1:0] dout;
  logic [1:0]   dout_sel;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;

  modport master (
    output xk_in, zk_in, zk_prime_in, in_valid, in_last, rate_half, dout_ready,
    input  in_ready, dout, dout_sel, dout_valid, dout_last
  );

  modport slave (
    input  xk_in, zk_in, zk_prime_in, in_valid, in_last, rate_half, dout_ready,
    output in_ready, dout, dout_sel, dout_valid, dout_last
  );
endinterface

// File: rtl/coder_stream_serializer.sv
// Buffers encoder triplets in a register FIFO and serialises them lane by lane.
// Optional rate-1/2 puncturing is enabled by defining CODER_PUNCTURE_EN.
module coder_stream_serializer #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  coder_stream_serializer_if.slave bus,
  output logic [LW-1:0]            level,
  output logic                     overflow_err
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic         last;
    logic [W-1:0] xk;
    logic [W-1:0] zk;
    logic [W-1:0] zkp;
  } entry_t;

  typedef enum logic [1:0] {
    LANE_X  = 2'd0,
    LANE_Z  = 2'd1,
    LANE_ZP = 2'd2
  } lane_e;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic          overflow_reg;
  lane_e         state_reg;
  lane_e         state_next;

  entry_t head;
  logic   empty;
  logic   full;
  logic   push;
  logic   pop;
  logic   accept;
  logic   final_lane;
  logic   punct;
  logic   parity_toggle;

  assign head   = mem[rd_ptr_reg];
  assign empty  = (count_reg == '0);
  assign full   = (count_reg == LW'(DEPTH));
  assign push   = bus.in_valid && !full;
  assign accept = !empty && bus.dout_ready;
  assign pop    = accept && final_lane;

  assign bus.in_ready   = !full;
  assign bus.dout_valid = !empty;
  assign bus.dout_last  = head.last && final_lane;
  assign level          = count_reg;
  assign overflow_err   = overflow_reg;

`ifdef CODER_PUNCTURE_EN
  logic half_mem [DEPTH];
  logic toggle_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      half_mem[wr_ptr_reg] <= bus.rate_half;
    end
  end

  // Every block restarts on zk, whatever mode its last entry used.
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_reg <= 1'b0;
    end else if (pop) begin
      if (head.last) begin
        toggle_reg <= 1'b0;
      end else if (punct) begin
        toggle_reg <= !toggle_reg;
      end
    end
  end

  assign punct         = half_mem[rd_ptr_reg];
  assign parity_toggle = toggle_reg;
`else
  logic unused_rate_half;
  assign unused_rate_half = bus.rate_half;
  assign punct            = 1'b0;
  assign parity_toggle    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= '{last: bus.in_last, xk: bus.xk_in, zk: bus.zk_in, zkp: bus.zk_prime_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= LANE_X;
    end else begin
      state_reg <= state_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
      if (bus.in_valid && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // A punctured entry jumps from X straight to the parity lane picked by the toggle.
  always_comb begin
    state_next   = state_reg;
    final_lane   = 1'b0;
    bus.dout     = head.xk;
    bus.dout_sel = 2'd0;
    case (state_reg)
      LANE_X: begin
        bus.dout     = head.xk;
        bus.dout_sel = 2'd0;
        if (accept) begin
          state_next = (punct && parity_toggle) ? LANE_ZP : LANE_Z;
        end
      end
      LANE_Z: begin
        bus.dout     = head.zk;
        bus.dout_sel = 2'd1;
        final_lane   = punct;
        if (accept) begin
          state_next = punct ? LANE_X : LANE_ZP;
        end
      end
      LANE_ZP: begin
        bus.dout     = head.zkp;
        bus.dout_sel = 2'd2;
        final_lane   = 1'b1;
        if (accept) begin
          state_next = LANE_X;
        end
      end
      default: begin
        state_next = LANE_X;
      end
    endcase
  end
endmodule
